// File: rtl/femtosoc_mem_bridge.sv
// femtosoc_mem_bridge
//
// Memory/IO bridge placed directly on the FemtoRV32 memory port. Serves
// every fetch, load and store: on-chip RAM is a word-wide array with byte
// write enables, and IO-space accesses (mem_addr[IO_BIT] = 1) are forwarded
// to a single-outstanding request/acknowledge peripheral port. IO accesses
// that never see io_ack are aborted after IO_TIMEOUT cycles and flag the
// sticky bus_err bit.
//
// Optional feature macro: MEM_BRIDGE_RAM_WAIT_EN
//   defined   - RAM reads spend one cycle in RAM_WAIT (mem_rbusy = 1) and
//               the data is valid two cycles after mem_rstrb.
//   undefined - RAM reads complete in one cycle without wait states.
//
// Parameters
//   RAM_WORDS  : RAM depth in 32-bit words (power of two)
//   IO_BIT     : address bit selecting IO space
//   IO_TIMEOUT : max cycles waiting for io_ack (1..255)
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   mem_addr/wdata/wmask: core byte address, aligned store data, byte enables
//   mem_rstrb           : one-cycle read strobe
//   mem_rdata           : registered read data
//   mem_rbusy/mem_wbusy : read / write wait states
//   io_addr/wdata/wmask : latched IO request fields
//   io_rd/io_wr         : one-cycle IO request pulses
//   io_rdata/io_ack     : IO completion data and strobe
//   bus_err             : sticky IO timeout flag

module femtosoc_mem_bridge #(
    parameter int RAM_WORDS  = 4096,
    parameter int IO_BIT     = 22,
    parameter int IO_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic [31:0] io_addr,
    output logic [31:0] io_wdata,
    output logic [3:0]  io_wmask,
    output logic        io_rd,
    output logic        io_wr,
    input  logic [31:0] io_rdata,
    input  logic        io_ack,
    output logic        bus_err
);

    localparam int         AW       = $clog2(RAM_WORDS);
    localparam logic [7:0] TMO_LAST = 8'(IO_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_IO_RD    = 2'd1,
        S_IO_WR    = 2'd2
`ifdef MEM_BRIDGE_RAM_WAIT_EN
        ,
        S_RAM_WAIT = 2'd3
`endif
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [31:0] r_ram [RAM_WORDS];

    logic [31:0] r_mem_rdata;
    logic [31:0] r_io_addr;
    logic [31:0] r_io_wdata;
    logic [3:0]  r_io_wmask;
    logic        r_io_rd;
    logic        r_io_wr;
    logic        r_bus_err;
    logic [7:0]  r_tmo_cnt;

    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_is_io;
    logic          w_in_io;
    logic          w_tmo_hit;
    logic          w_ram_wr;
    logic          w_ram_rd;
    logic          w_ram_rd_req;
    logic          w_io_rd_go;
    logic          w_io_wr_go;
    logic          w_io_rd_done;
    logic          w_io_rd_tmo;
    logic          w_tmo;
    logic          w_unused;

    assign w_idx     = mem_addr[AW+1:2];
    assign w_is_io   = mem_addr[IO_BIT];
    assign w_in_io   = (r_state == S_IO_RD) || (r_state == S_IO_WR);
    // Counter started at 0 on the request edge, so the last permitted
    // wait cycle is the one where it holds IO_TIMEOUT-1.
    assign w_tmo_hit = (r_tmo_cnt == TMO_LAST);

    // Address bits outside the RAM index and the IO select are ignored
    // on purpose: RAM aliases across the whole non-IO space.
    assign w_unused  = ^{mem_addr, w_ram_rd_req};

`ifdef MEM_BRIDGE_RAM_WAIT_EN
    logic [AW-1:0] r_rd_idx;

    // The read index must survive the wait cycle; the core may change
    // mem_addr once the strobe has been taken.
    always_ff @(posedge clk) begin
        if (w_ram_rd_req) begin
            r_rd_idx <= w_idx;
        end
    end

    assign w_rd_idx = r_rd_idx;
`else
    assign w_rd_idx = w_idx;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and per-cycle control decode
    always_comb begin
        w_state_nxt  = r_state;
        w_ram_wr     = 1'b0;
        w_ram_rd     = 1'b0;
        w_ram_rd_req = 1'b0;
        w_io_rd_go   = 1'b0;
        w_io_wr_go   = 1'b0;
        w_io_rd_done = 1'b0;
        w_io_rd_tmo  = 1'b0;
        w_tmo        = 1'b0;

        case (r_state)
            S_IDLE: begin
                // A write with a simultaneous read strobe drops the read.
                if (mem_wmask != 4'b0000) begin
                    if (w_is_io) begin
                        w_io_wr_go  = 1'b1;
                        w_state_nxt = S_IO_WR;
                    end else begin
                        w_ram_wr = 1'b1;
                    end
                end else if (mem_rstrb) begin
                    if (w_is_io) begin
                        w_io_rd_go  = 1'b1;
                        w_state_nxt = S_IO_RD;
                    end else begin
                        w_ram_rd_req = 1'b1;
`ifdef MEM_BRIDGE_RAM_WAIT_EN
                        w_state_nxt  = S_RAM_WAIT;
`else
                        w_ram_rd     = 1'b1;
`endif
                    end
                end
            end

            S_IO_RD: begin
                // Ack has priority over the timeout on the same cycle.
                if (io_ack) begin
                    w_io_rd_done = 1'b1;
                    w_state_nxt  = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_io_rd_tmo = 1'b1;
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

            S_IO_WR: begin
                if (io_ack) begin
                    w_state_nxt = S_IDLE;
                end else if (w_tmo_hit) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end

`ifdef MEM_BRIDGE_RAM_WAIT_EN
            S_RAM_WAIT: begin
                w_ram_rd    = 1'b1;
                w_state_nxt = S_IDLE;
            end
`endif

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // RAM array: byte-lane writes, contents deliberately not reset
    always_ff @(posedge clk) begin
        if (!reset && w_ram_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wmask[b]) begin
                    r_ram[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data, IO request latches, timeout counter and error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_rdata <= '0;
            r_io_addr   <= '0;
            r_io_wdata  <= '0;
            r_io_wmask  <= '0;
            r_io_rd     <= 1'b0;
            r_io_wr     <= 1'b0;
            r_bus_err   <= 1'b0;
            r_tmo_cnt   <= '0;
        end else begin
            // Pulses last exactly the cycle after the request edge.
            r_io_rd <= w_io_rd_go;
            r_io_wr <= w_io_wr_go;

            if (w_io_rd_go || w_io_wr_go) begin
                r_io_addr <= mem_addr;
            end
            if (w_io_wr_go) begin
                r_io_wdata <= mem_wdata;
                r_io_wmask <= mem_wmask;
            end

            if (w_ram_rd) begin
                r_mem_rdata <= r_ram[w_rd_idx];
            end else if (w_io_rd_done) begin
                r_mem_rdata <= io_rdata;
            end else if (w_io_rd_tmo) begin
                r_mem_rdata <= 32'hFFFF_FFFF;
            end

            if (w_tmo) begin
                r_bus_err <= 1'b1;
            end

            if (w_io_rd_go || w_io_wr_go) begin
                r_tmo_cnt <= '0;
            end else if (w_in_io) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
        end
    end

    assign mem_rdata = r_mem_rdata;
    assign io_addr   = r_io_addr;
    assign io_wdata  = r_io_wdata;
    assign io_wmask  = r_io_wmask;
    assign io_rd     = r_io_rd;
    assign io_wr     = r_io_wr;
    assign bus_err   = r_bus_err;

    // Busy flags decode registered state only, so they rise in the cycle
    // after the request edge.
`ifdef MEM_BRIDGE_RAM_WAIT_EN
    assign mem_rbusy = (r_state == S_IO_RD) || (r_state == S_RAM_WAIT);
`else
    assign mem_rbusy = (r_state == S_IO_RD);
`endif
    assign mem_wbusy = (r_state == S_IO_WR);

endmodule

// File: doc/femtosoc_mem_bridge.md
# femtosoc_mem_bridge

Memory/IO bridge that sits directly downstream of the FemtoRV32 core's memory port and serves every fetch, load and store it issues. It holds the on-chip RAM as a word-wide array with byte write enables, and forwards IO-space accesses to a request/acknowledge peripheral port. It generates `mem_rbusy`/`mem_wbusy` wait states. IO accesses that never complete are aborted by a timeout counter and flagged with a sticky error bit.

## Interface
- `RAM_WORDS`, 4096: RAM depth in 32-bit words; power of two.
- `IO_BIT`, 22: address bit selecting IO space (1 = IO, 0 = RAM).
- `IO_TIMEOUT`, 15: maximum cycles spent waiting for `io_ack`; range 1..255.

- `clk`, in, 1: single clock; all state changes on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `mem_addr`, in, 32: byte address from the core.
- `mem_wdata`, in, 32: store data, already byte-lane aligned.
- `mem_wmask`, in, 4: byte write enables; nonzero means a write request.
- `mem_rstrb`, in, 1: read request strobe, one cycle.
- `mem_rdata`, out, 32: registered read data.
- `mem_rbusy`, out, 1: read in progress.
- `mem_wbusy`, out, 1: write in progress.
- `io_addr`, out, 32: latched IO address.
- `io_wdata`, out, 32: latched IO write data.
- `io_wmask`, out, 4: latched IO byte mask.
- `io_rd`, out, 1: one-cycle IO read pulse.
- `io_wr`, out, 1: one-cycle IO write pulse.
- `io_rdata`, in, 32: IO read data, valid with `io_ack`.
- `io_ack`, in, 1: IO completion, one cycle.
- `bus_err`, out, 1: sticky IO timeout flag.

## Operation
- States: IDLE, IO_RD, IO_WR, plus RAM_WAIT when `MEM_BRIDGE_RAM_WAIT_EN` is defined.
- Request decode happens in IDLE only. Requests arriving in any other state are ignored.
- If `mem_wmask`≠0 and `mem_rstrb` are asserted together, the write wins and the read is dropped.
- RAM index is `mem_addr[log2(RAM_WORDS)+1:2]`. Upper non-IO bits are ignored, so RAM aliases and wraps.
- **RAM write:** bytes with `mem_wmask[i]`=1 are written at the same edge. `mem_wbusy` stays 0 and the state stays IDLE.
- **RAM read:** the word is registered into `mem_rdata` at the edge after `mem_rstrb`. `mem_rbusy` stays 0.
- **IO read:** at the request edge:
  - latch `io_addr` = `mem_addr`;
  - pulse `io_rd` for the next cycle;
  - enter IO_RD and clear the timeout counter.
- **IO write:** at the request edge:
  - latch `io_addr`, `io_wdata` and `io_wmask`;
  - pulse `io_wr` for the next cycle;
  - enter IO_WR.
- **Completion in IO_RD/IO_WR:** when `io_ack`=1, `mem_rdata` <= `io_rdata` (IO_RD only) and the state returns to IDLE.
- **Timeout:** the counter increments each cycle spent in IO_RD/IO_WR. When it reaches `IO_TIMEOUT` without an ack:
  - return to IDLE;
  - set `bus_err`;
  - on a read, `mem_rdata` <= 32'hFFFF_FFFF.
- An `io_ack` arriving on the timeout cycle counts as success.
- `io_ack` in IDLE is ignored.
- `bus_err` is cleared only by reset.

## Timing
- Reset values:
  - state IDLE;
  - `mem_rdata`=0, `mem_rbusy`=0, `mem_wbusy`=0;
  - `io_rd`=0, `io_wr`=0, `io_addr`=0, `io_wdata`=0, `io_wmask`=0;
  - `bus_err`=0;
  - timeout counter 0.
- RAM contents are not reset.
- Reset mid-transaction aborts it immediately, with no further `io_rd`/`io_wr` pulse.
- `mem_rbusy` = (state==IO_RD), or (state==RAM_WAIT). `mem_wbusy` = (state==IO_WR). Both are combinational from registered state, so they are high in the cycle after the request edge. The core samples them in that cycle.
- **RAM read latency:** 1 cycle, no busy.
- **IO latency:** request edge, then `io_rd`/`io_wr` high for cycle 1. Ack seen in cycle N returns to IDLE at the end of N. Busy is low and data valid in cycle N+1.
- A peripheral ack in cycle 1 (same cycle as the pulse) is legal.
- Worst case: busy for `IO_TIMEOUT` cycles.

## Configuration
- `MEM_BRIDGE_RAM_WAIT_EN`:
  - **Defined:** a RAM read enters RAM_WAIT for exactly one cycle (`mem_rbusy`=1). Data is registered at the end of RAM_WAIT and is valid 2 cycles after `mem_rstrb`. This is for slow BRAM timing.
  - **Undefined:** the RAM_WAIT state and its logic are absent and RAM reads are 1-cycle.
- RAM writes are unaffected either way.

## Test plan
- **RAM byte write and read:** write 32'hDEADBEEF mask 1111 at 0x100, then mask 0010 with wdata 32'h0000AA00. Read 0x100 -> `mem_rdata`=32'hDEADAAEF one cycle later, `mem_rbusy` never high.
- **IO read:** read at 0x0040_0008 with `io_ack` after 3 cycles and `io_rdata`=32'h12345678. Require `io_rd` high 1 cycle and `mem_rbusy` high 3 cycles. In the following cycle, `mem_rdata`=32'h12345678 and busy is 0.
- **IO write:** write 32'h55 mask 0001 at 0x0040_0004 with same-cycle ack. Require `io_wr`=1, `io_wmask`=0001, `mem_wbusy` high exactly 1 cycle.
- **Timeout:** IO read with no ack, `IO_TIMEOUT`=15. Require `mem_rbusy` high 15 cycles, then `mem_rdata`=32'hFFFFFFFF and `bus_err`=1. `bus_err` stays set through later good accesses.
- **Reset mid-IO-write:** assert `reset` in cycle 2 of IO_WR. Next cycle all outputs are at reset values, and a late `io_ack` is ignored.
- **With `MEM_BRIDGE_RAM_WAIT_EN`:** a RAM read of 0x100 -> `mem_rbusy`=1 for exactly one cycle, data valid on cycle 2.
